// File: rtl/div_msb_seq_ctrl_if.sv
// Issue/writeback bundle for the msb-driven sequential divider.
// Master drives requests and abort; slave returns results.
interface div_msb_seq_ctrl_if;
  logic        start;
  logic        start_ready;
  logic        abort;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;

  modport master (
    output start, abort, dividend, divisor,
    input  start_ready, done, quotient,
    input  remainder, busy
  );

  modport slave (
    input  start, abort, dividend, divisor,
    output start_ready, done, quotient,
    output remainder, busy
  );
endinterface

// File: rtl/div_msb_seq_ctrl.sv
// Early-terminating radix-2 unsigned divider sequencer.
// One leading-one unit is time-shared between dividend and divisor.
module div_msb_seq_ctrl #(
  parameter logic [31:0] ZERO_DIV_QUOTIENT = 32'hFFFF_FFFF,
  parameter bit          EARLY_OUT         = 1'b1
) (
  input logic               clk,
  input logic               rst,
  div_msb_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSB_A,
    S_MSB_B,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_d;
  logic [31:0] r_r;
  logic [31:0] r_q;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [4:0]  r_msb_a;
  logic [4:0]  r_count;
  logic [4:0]  w_msb;
  logic [4:0]  w_shift;
  logic [31:0] w_msb_in;
  logic [31:0] w_r_nxt;
  logic [31:0] w_q_nxt;
  logic        w_ready;
  logic        w_accept;
  logic        w_b_zero;
  logic        w_early;
  logic        w_ge;

  assign w_ready = (r_state == S_IDLE ||
                    r_state == S_DONE) &&
                   !bus.abort;
  assign w_accept = bus.start && w_ready;

  // the single msb unit: dividend in MSB_A, divisor in MSB_B
  assign w_msb_in = (r_state == S_MSB_B) ? r_b : r_a;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_msb_in[i]) w_msb = 5'(i);
    end
  end

  assign w_b_zero = (r_b == '0);
  assign w_early  = EARLY_OUT && (r_msb_a < w_msb);
  assign w_shift  = (r_msb_a >= w_msb) ?
                    (r_msb_a - w_msb) : '0;

  assign w_ge    = ({1'b0, r_r} >= {1'b0, r_d});
  assign w_r_nxt = w_ge ? (r_r - r_d) : r_r;
  assign w_q_nxt = (r_q << 1) | 32'(w_ge);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_MSB_A;
      S_MSB_A:  w_next = S_MSB_B;
      S_MSB_B:  w_next = (w_b_zero || w_early) ?
                         S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_count == '0) w_next = S_DONE;
      S_DONE:   w_next = w_accept ? S_MSB_A : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_msb_a <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (!bus.abort) begin
        if (w_accept) begin
          r_a <= bus.dividend;
          r_b <= bus.divisor;
        end
        unique case (r_state)
          S_MSB_A: r_msb_a <= w_msb;
          S_MSB_B: begin
            if (w_b_zero) begin
              r_quot <= ZERO_DIV_QUOTIENT;
              r_rem  <= r_a;
            end else if (w_early) begin
              r_quot <= '0;
              r_rem  <= r_a;
            end else begin
              r_d     <= r_b << w_shift;
              r_r     <= r_a;
              r_q     <= '0;
              r_count <= w_shift;
            end
          end
          S_DIVIDE: begin
            r_r <= w_r_nxt;
            r_q <= w_q_nxt;
            r_d <= r_d >> 1;
            if (r_count == '0) begin
              r_quot <= w_q_nxt;
              r_rem  <= w_r_nxt;
            end else begin
              r_count <= r_count - 5'd1;
            end
          end
          S_IDLE, S_DONE: ;
          default: ;
        endcase
      end
    end
  end

  assign bus.start_ready = w_ready;
  assign bus.done        = (r_state == S_DONE);
  assign bus.busy        = (r_state == S_MSB_A) ||
                           (r_state == S_MSB_B) ||
                           (r_state == S_DIVIDE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;

endmodule

// File: tb/tb_div_msb_seq_ctrl.sv
// Scoreboard bench for div_msb_seq_ctrl.
// Expected results and latencies come from plain arithmetic.
module tb_div_msb_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_msb_seq_ctrl_if bus();

  div_msb_seq_ctrl #(
    .ZERO_DIV_QUOTIENT(32'hFFFF_FFFF),
    .EARLY_OUT(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] hold_q = '0;
  logic [31:0] hold_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic int msbi(input logic [31:0] x);
    int m = 0;
    for (int i = 0; i < 32; i++)
      if (x[i]) m = i;
    return m;
  endfunction

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    e.acc = 0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 3;
    end else if (msbi(a) < msbi(b)) begin
      e.q = 0; e.r = a; e.lat = 3;
    end else begin
      e.q = a / b; e.r = a % b;
      e.lat = 4 + msbi(a) - msbi(b);
    end
    return e;
  endfunction

  // monitor: sample well clear of both clock edges
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("latency", 32'(cyc - e.acc + 1),
              32'(e.lat));
          hold_q = e.q;
          hold_r = e.r;
        end
      end else begin
        chk("hold_quotient", bus.quotient, hold_q);
        chk("hold_remainder", bus.remainder, hold_r);
      end
    end
  end

  // called at a negedge; returns at the negedge after accept
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int   n = 0;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    #1;
    while (!bus.start_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got busy expected ready");
        bus.start = 1'b0;
        return;
      end
    end
    e = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.start = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.start_ready), 1);

    // back-to-back: 9/3 held during the DONE of 100/7
    issue(32'd100, 32'd7);
    issue(32'd9, 32'd3);
    drain();
    issue(32'h1234_5678, 32'd0);
    drain();
    issue(32'd5, 32'h100);
    drain();
    issue(32'hFFFF_FFFF, 32'd1);
    drain();
    issue(32'h8000_0000, 32'd3);
    drain();
    issue(32'd0, 32'd9);
    drain();

    // abort with start in the third divide cycle
    issue(32'd100, 32'd7);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_pre_abort", 32'(bus.busy), 1);
    bus.abort    = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 32'd55;
    bus.divisor  = 32'd5;
    #1;
    chk("abort_ready", 32'(bus.start_ready), 0);
    void'(sb.pop_back());
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    repeat (40) @(negedge clk);

    // reset in the middle of a long divide
    issue(32'hFFFF_FFFF, 32'd1);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_pre_rst", 32'(bus.busy), 1);
    rst    = 1'b1;
    hold_q = '0;
    hold_r = '0;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_quotient", bus.quotient, 0);
    chk("mid_rst_remainder", bus.remainder, 0);
    repeat (40) @(negedge clk);

    for (int k = 0; k < 150; k++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0)
        b = '0;
      else
        b = $urandom >> $urandom_range(0, 31);
      issue(a, b);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.start = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
